// File: rtl/hazard_ctrl.sv
// hazard_ctrl: EX-stage operand hazard and pipeline stall/flush controller.
//
// Handles three hazard cases:
//   - Load-use hazards. A single-operand match is forwarded from the load in MEM. A
//     dual-operand match inserts DUAL_BUBBLES bubbles so the regfile supplies both
//     operands (write-first).
//   - Data-memory wait states. The pipeline is frozen and mem_timeout_err_o pulses
//     after WAIT_MAX consecutive not-ready cycles.
//   - Taken branches. IF/ID and ID/EX are flushed.
//
// Priority: memory wait freeze > branch flush > dual-match bubble > normal advance.
// Stall and flush outputs are combinational. forward_to_alu_o and mem_timeout_err_o are
// registered.
//
// Optional feature: define HAZARD_PERF_CNT_EN to add the 32-bit wrapping counters
// stall_cycles_o, flush_cnt_o and fwd_cnt_o.
//
// Ports:
//   clk_i             core clock
//   rst_i             synchronous active-high reset
//   id_rs1_i/rs2_i    ID-stage source register addresses
//   id_alu_src_sel_i  ID-stage ALU source select (REG uses rs1+rs2, IMM uses rs1)
//   ex_is_load_i      EX-stage instruction is a load
//   ex_rd_i           EX-stage destination register
//   mem_req_i         MEM-stage access active
//   mem_ready_i       data memory completed the access
//   branch_taken_i    EX-stage redirect
//   pc_stall_o, if_id_stall_o, id_ex_stall_o   hold PC / IF/ID / ID/EX
//   if_id_flush_o, id_ex_flush_o               clear IF/ID / ID/EX to NOP
//   forward_to_alu_o  [0]=src1, [1]=src2 take MEM load data (registered)
//   mem_timeout_err_o one-cycle pulse on wait timeout

`ifndef ALU_SRC_WIDTH
`define ALU_SRC_WIDTH 2
`endif
`ifndef ALU_SRC_REG
`define ALU_SRC_REG 2'd0
`endif
`ifndef ALU_SRC_IMM
`define ALU_SRC_IMM 2'd1
`endif

module hazard_ctrl #(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned WAIT_MAX     = 15,
    parameter int unsigned DUAL_BUBBLES = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [REG_AW-1:0]         id_rs1_i,
    input  logic [REG_AW-1:0]         id_rs2_i,
    input  logic [`ALU_SRC_WIDTH-1:0] id_alu_src_sel_i,
    input  logic                      ex_is_load_i,
    input  logic [REG_AW-1:0]         ex_rd_i,
    input  logic                      mem_req_i,
    input  logic                      mem_ready_i,
    input  logic                      branch_taken_i,
    output logic                      pc_stall_o,
    output logic                      if_id_stall_o,
    output logic                      id_ex_stall_o,
    output logic                      if_id_flush_o,
    output logic                      id_ex_flush_o,
    output logic [1:0]                forward_to_alu_o,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]               stall_cycles_o,
    output logic [31:0]               flush_cnt_o,
    output logic [31:0]               fwd_cnt_o,
`endif
    output logic                      mem_timeout_err_o
);

    localparam int unsigned WCW = $clog2(WAIT_MAX + 1);
    localparam int unsigned BCW = $clog2(DUAL_BUBBLES + 1);

    typedef enum logic [1:0] {StRun, StDual, StWait} state_e;

    state_e           state_q, state_d;
    state_e           ret_q, ret_d;     // state to resume once memory is ready
    state_e           cur;
    logic [BCW-1:0]   bub_q, bub_d;     // bubbles already issued for the current dual match
    logic [BCW-1:0]   bub_next;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [1:0]       fwd_q, fwd_d;
    logic             err_q, err_d;
    logic             use1, use2, m1, m2, freeze;

    assign use1 = (id_alu_src_sel_i == `ALU_SRC_REG) || (id_alu_src_sel_i == `ALU_SRC_IMM);
    assign use2 = (id_alu_src_sel_i == `ALU_SRC_REG);
    assign m1   = use1 & ex_is_load_i & (id_rs1_i == ex_rd_i) & (ex_rd_i != '0);
    assign m2   = use2 & ex_is_load_i & (id_rs2_i == ex_rd_i) & (ex_rd_i != '0);

    // Once in WAIT only mem_ready matters; from other states a new miss starts the freeze.
    assign freeze = (state_q == StWait) ? ~mem_ready_i : (mem_req_i & ~mem_ready_i);
    // A wait cycle that completes behaves like the interrupted state.
    assign cur    = (state_q == StWait) ? ret_q : state_q;

    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        bub_d         = bub_q;
        bub_next      = '0;
        wait_cnt_d    = '0;
        err_d         = 1'b0;
        fwd_d         = fwd_q;
        pc_stall_o    = 1'b0;
        if_id_stall_o = 1'b0;
        id_ex_stall_o = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;

        if (freeze) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_stall_o = 1'b1;
            if (state_q != StWait) begin
                ret_d   = state_q;
                state_d = StWait;
            end
            wait_cnt_d = (wait_cnt_q == WCW'(WAIT_MAX)) ? wait_cnt_q : wait_cnt_q + 1'b1;
            err_d      = (wait_cnt_q == WCW'(WAIT_MAX - 1));
        end else if (branch_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            fwd_d         = 2'b00;
            state_d       = StRun;
            bub_d         = '0;
        end else if ((cur == StDual) || (m1 & m2)) begin
            // The detecting cycle is itself the first bubble.
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
            fwd_d         = 2'b00;
            bub_next      = ((cur == StDual) ? bub_q : '0) + 1'b1;
            if (bub_next >= BCW'(DUAL_BUBBLES)) begin
                state_d = StRun;
                bub_d   = '0;
            end else begin
                state_d = StDual;
                bub_d   = bub_next;
            end
        end else begin
            fwd_d   = {m2, m1};
            state_d = StRun;
        end

        if (rst_i) begin
            pc_stall_o    = 1'b0;
            if_id_stall_o = 1'b0;
            id_ex_stall_o = 1'b0;
            if_id_flush_o = 1'b0;
            id_ex_flush_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StRun;
            ret_q      <= StRun;
            bub_q      <= '0;
            wait_cnt_q <= '0;
            fwd_q      <= 2'b00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            bub_q      <= bub_d;
            wait_cnt_q <= wait_cnt_d;
            fwd_q      <= fwd_d;
            err_q      <= err_d;
        end
    end

    assign forward_to_alu_o  = fwd_q;
    assign mem_timeout_err_o = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, flush_cnt_q, fwd_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles_q <= '0;
            flush_cnt_q    <= '0;
            fwd_cnt_q      <= '0;
        end else begin
            if (pc_stall_o)    stall_cycles_q <= stall_cycles_q + 32'd1;
            // if_id_flush is only ever raised by a branch flush
            if (if_id_flush_o) flush_cnt_q    <= flush_cnt_q + 32'd1;
            if (!id_ex_stall_o && !id_ex_flush_o && (fwd_d != 2'b00))
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_cnt_o    = flush_cnt_q;
    assign fwd_cnt_o      = fwd_cnt_q;
`endif

endmodule
